// File: rtl/stream_demux_1x2_pkg.sv
// Shared definitions for the stream_demux_1x2 block.
//   DEMUX_SEL_A / DEMUX_SEL_B : dataSel encodings for the two destinations
//   DEMUX_BIT_SIZE            : default data width
//   DEMUX_CNT_WIDTH           : default delivered-beat counter width
//   fifo2_state_t             : occupancy state of the 2-entry output FIFO
package stream_demux_1x2_pkg;

  localparam logic DEMUX_SEL_A = 1'b0;
  localparam logic DEMUX_SEL_B = 1'b1;

  localparam int DEMUX_BIT_SIZE  = 32;
  localparam int DEMUX_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_ONE,
    FIFO_FULL
  } fifo2_state_t;

endpackage

// File: rtl/stream_demux_1x2_if.sv
// Handshake bundle of the 1-to-2 stream demultiplexer.
//   Input stream : dataIn, dataSel, dataInValid (to demux), dataInReady (from demux)
//   Output A     : dataOutA, validA (from demux), readyA (to demux), countA
//   Output B     : dataOutB, validB (from demux), readyB (to demux), countB
// Modports:
//   slave  - the demux itself
//   master - the environment (producer plus both consumers)
interface stream_demux_1x2_if #(
  parameter int BIT_SIZE  = stream_demux_1x2_pkg::DEMUX_BIT_SIZE,
  parameter int CNT_WIDTH = stream_demux_1x2_pkg::DEMUX_CNT_WIDTH
);

  logic [BIT_SIZE-1:0]  dataIn;
  logic                 dataSel;
  logic                 dataInValid;
  logic                 dataInReady;
  logic [BIT_SIZE-1:0]  dataOutA;
  logic                 validA;
  logic                 readyA;
  logic [BIT_SIZE-1:0]  dataOutB;
  logic                 validB;
  logic                 readyB;
  logic [CNT_WIDTH-1:0] countA;
  logic [CNT_WIDTH-1:0] countB;

  modport slave (
    input  dataIn, dataSel, dataInValid, readyA, readyB,
    output dataInReady, dataOutA, validA, dataOutB, validB, countA, countB
  );

  modport master (
    output dataIn, dataSel, dataInValid, readyA, readyB,
    input  dataInReady, dataOutA, validA, dataOutB, validB, countA, countB
  );

endinterface

// File: rtl/stream_demux_1x2_fifo.sv
// fifo_2entry: two-slot register FIFO used on each demux output.
// Ports:
//   clk, resetN : clock, asynchronous active-low reset
//   pushData    : data written on push
//   push, pop   : requests; ignored when they cannot be honoured
//   headData    : oldest entry; holds its last value while empty (0 after reset)
//   notEmpty    : at least one entry buffered
//   full        : both slots occupied
module fifo_2entry
  import stream_demux_1x2_pkg::*;
#(
  parameter int BIT_SIZE = DEMUX_BIT_SIZE
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [BIT_SIZE-1:0] pushData,
  input  logic                push,
  input  logic                pop,
  output logic [BIT_SIZE-1:0] headData,
  output logic                notEmpty,
  output logic                full
);

  fifo2_state_t        state_q, state_d;
  logic [BIT_SIZE-1:0] head_q, head_d;
  logic [BIT_SIZE-1:0] tail_q, tail_d;
  logic                do_push, do_pop;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop & (state_q != FIFO_EMPTY);
    // A push into a full FIFO is legal only when a pop frees a slot this cycle.
    do_push = push & ((state_q != FIFO_FULL) | do_pop);
    case (state_q)
      FIFO_EMPTY: begin
        if (do_push) begin
          head_d  = pushData;
          state_d = FIFO_ONE;
        end
      end
      FIFO_ONE: begin
        if (do_push && do_pop) begin
          head_d = pushData;
        end else if (do_push) begin
          tail_d  = pushData;
          state_d = FIFO_FULL;
        end else if (do_pop) begin
          // Head is left untouched so the output keeps its last value.
          state_d = FIFO_EMPTY;
        end
      end
      FIFO_FULL: begin
        if (do_pop) begin
          head_d = tail_q;
          if (do_push) begin
            tail_d = pushData;
          end else begin
            state_d = FIFO_ONE;
          end
        end
      end
      default: state_d = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= FIFO_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign headData = head_q;
  assign notEmpty = (state_q != FIFO_EMPTY);
  assign full     = (state_q == FIFO_FULL);

endmodule

// File: rtl/stream_demux_1x2.sv
// stream_demux_1x2: routes one valid/ready stream to output A or B, chosen per
// beat by dataSel. Each output is decoupled by a 2-entry FIFO so a stalled
// consumer only blocks beats headed to its own output once its FIFO is full.
// Ports:
//   clk    : rising-edge clock
//   resetN : asynchronous active-low reset (clears FIFOs and counters)
//   bus    : stream_demux_1x2_if.slave (input stream, outputs A/B, counters)
module stream_demux_1x2
  import stream_demux_1x2_pkg::*;
#(
  parameter int BIT_SIZE  = DEMUX_BIT_SIZE,
  parameter int CNT_WIDTH = DEMUX_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetN,
  stream_demux_1x2_if.slave    bus
);

  logic                 rdy_en_q, rdy_en_d;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;

  logic [BIT_SIZE-1:0]  head_a, head_b;
  logic                 not_empty_a, not_empty_b;
  logic                 full_a, full_b;
  logic                 pop_a, pop_b;
  logic                 push_a, push_b;
  logic                 in_ready, in_fire;

  always_comb begin
    pop_a = not_empty_a & bus.readyA;
    pop_b = not_empty_b & bus.readyB;
    // Ready tracks the selected destination; a pop in the same cycle frees a slot.
    // rdy_en_q keeps ready low until the first clock edge after reset release.
    if (bus.dataSel == DEMUX_SEL_B) begin
      in_ready = rdy_en_q & (~full_b | pop_b);
    end else begin
      in_ready = rdy_en_q & (~full_a | pop_a);
    end
    in_fire  = bus.dataInValid & in_ready;
    push_a   = in_fire & (bus.dataSel == DEMUX_SEL_A);
    push_b   = in_fire & (bus.dataSel == DEMUX_SEL_B);
    rdy_en_d = 1'b1;
    cnt_a_d  = cnt_a_q + {{(CNT_WIDTH-1){1'b0}}, pop_a};
    cnt_b_d  = cnt_b_q + {{(CNT_WIDTH-1){1'b0}}, pop_b};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rdy_en_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

  fifo_2entry #(.BIT_SIZE(BIT_SIZE)) u_fifo_a (
    .clk      (clk),
    .resetN   (resetN),
    .pushData (bus.dataIn),
    .push     (push_a),
    .pop      (pop_a),
    .headData (head_a),
    .notEmpty (not_empty_a),
    .full     (full_a)
  );

  fifo_2entry #(.BIT_SIZE(BIT_SIZE)) u_fifo_b (
    .clk      (clk),
    .resetN   (resetN),
    .pushData (bus.dataIn),
    .push     (push_b),
    .pop      (pop_b),
    .headData (head_b),
    .notEmpty (not_empty_b),
    .full     (full_b)
  );

  assign bus.dataInReady = in_ready;
  assign bus.dataOutA    = head_a;
  assign bus.validA      = not_empty_a;
  assign bus.dataOutB    = head_b;
  assign bus.validB      = not_empty_b;
  assign bus.countA      = cnt_a_q;
  assign bus.countB      = cnt_b_q;

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Testbench for stream_demux_1x2: directed vector table plus hand-written
// reset, counter-wrap and randomized scoreboard sequences.
module tb_stream_demux_1x2;

  logic clk;
  logic resetN;

  stream_demux_1x2_if #(.BIT_SIZE(32), .CNT_WIDTH(16)) bus ();

  stream_demux_1x2 #(.BIT_SIZE(32), .CNT_WIDTH(16)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] din;
    logic        sel, vld, ra, rb;
    logic        rdy;
    logic        va;
    logic [31:0] da;
    logic        vb;
    logic [31:0] db;
    logic [15:0] ca, cb;
  } vec_t;

  vec_t vecs [17];

  // Scoreboard state for the random phase.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          exp_ca, exp_cb;

  task automatic model_cycle();
    logic        exp_rdy;
    logic [31:0] front;
    check("rand_validA", 32'(bus.validA), 32'(qa.size() != 0));
    check("rand_validB", 32'(bus.validB), 32'(qb.size() != 0));
    if (bus.dataSel)
      exp_rdy = (qb.size() < 2) || (bus.readyB && qb.size() != 0);
    else
      exp_rdy = (qa.size() < 2) || (bus.readyA && qa.size() != 0);
    check("rand_ready", 32'(bus.dataInReady), 32'(exp_rdy));
    if (bus.readyA && qa.size() != 0) begin
      front = qa.pop_front();
      check("rand_dataA", bus.dataOutA, front);
      exp_ca++;
    end
    if (bus.readyB && qb.size() != 0) begin
      front = qb.pop_front();
      check("rand_dataB", bus.dataOutB, front);
      exp_cb++;
    end
    if (bus.dataInValid && exp_rdy) begin
      if (bus.dataSel) qb.push_back(bus.dataIn);
      else             qa.push_back(bus.dataIn);
    end
  endtask

  task automatic idle_inputs();
    bus.dataIn      = 32'h0;
    bus.dataSel     = 1'b0;
    bus.dataInValid = 1'b0;
    bus.readyA      = 1'b0;
    bus.readyB      = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, del;

    //              din           sel   vld   ra    rb    rdy   va    da            vb    db            ca      cb
    vecs[0]  = '{32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000000, 16'd0, 16'd0};
    vecs[1]  = '{32'h11111111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h11111111, 16'd1, 16'd0};
    vecs[2]  = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h11111111, 16'd1, 16'd1};
    vecs[3]  = '{32'h00000001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000001, 1'b0, 32'h11111111, 16'd1, 16'd1};
    vecs[4]  = '{32'h00000002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000001, 1'b0, 32'h11111111, 16'd1, 16'd1};
    vecs[5]  = '{32'h00000003, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000001, 1'b0, 32'h11111111, 16'd1, 16'd1};
    vecs[6]  = '{32'h00000B01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 1'b1, 32'h00000B01, 16'd1, 16'd1};
    vecs[7]  = '{32'h00000003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000002, 1'b1, 32'h00000B01, 16'd2, 16'd1};
    vecs[8]  = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000003, 1'b0, 32'h00000B01, 16'd3, 16'd2};
    vecs[9]  = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000003, 1'b0, 32'h00000B01, 16'd4, 16'd2};
    vecs[10] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000003, 1'b0, 32'h00000B01, 16'd4, 16'd2};
    vecs[11] = '{32'h000000B1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000003, 1'b1, 32'h000000B1, 16'd4, 16'd2};
    vecs[12] = '{32'h000000B2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000003, 1'b1, 32'h000000B1, 16'd4, 16'd2};
    vecs[13] = '{32'h000000B3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000003, 1'b1, 32'h000000B1, 16'd4, 16'd2};
    vecs[14] = '{32'h000000A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000A5, 1'b1, 32'h000000B1, 16'd4, 16'd2};
    vecs[15] = '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000000A5, 1'b1, 32'h000000B2, 16'd5, 16'd3};
    vecs[16] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000000A5, 1'b0, 32'h000000B2, 16'd5, 16'd4};

    // Power-on reset.
    resetN = 1'b0;
    idle_inputs();
    #2;
    check("rst_validA", 32'(bus.validA), 32'h0);
    check("rst_validB", 32'(bus.validB), 32'h0);
    check("rst_countA", 32'(bus.countA), 32'h0);
    check("rst_countB", 32'(bus.countB), 32'h0);
    check("rst_dataOutA", bus.dataOutA, 32'h0);
    check("rst_dataOutB", bus.dataOutB, 32'h0);
    check("rst_ready", 32'(bus.dataInReady), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(bus.dataInReady), 32'h0);
    @(posedge clk);
    #1;
    check("ready_after_first_edge", 32'(bus.dataInReady), 32'h1);

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.dataIn      = vecs[i].din;
      bus.dataSel     = vecs[i].sel;
      bus.dataInValid = vecs[i].vld;
      bus.readyA      = vecs[i].ra;
      bus.readyB      = vecs[i].rb;
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus.dataInReady), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_validA", i), 32'(bus.validA), 32'(vecs[i].va));
      check($sformatf("v%0d_dataOutA", i), bus.dataOutA, vecs[i].da);
      check($sformatf("v%0d_validB", i), 32'(bus.validB), 32'(vecs[i].vb));
      check($sformatf("v%0d_dataOutB", i), bus.dataOutB, vecs[i].db);
      check($sformatf("v%0d_countA", i), 32'(bus.countA), 32'(vecs[i].ca));
      check($sformatf("v%0d_countB", i), 32'(bus.countB), 32'(vecs[i].cb));
    end

    // Reset mid-stream: buffer a beat on each side, then assert reset between edges.
    @(negedge clk);
    bus.dataIn = 32'h00000077; bus.dataSel = 1'b0; bus.dataInValid = 1'b1;
    bus.readyA = 1'b0; bus.readyB = 1'b0;
    @(negedge clk);
    bus.dataIn = 32'h00000088; bus.dataSel = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("pre_rst_validA", 32'(bus.validA), 32'h1);
    check("pre_rst_validB", 32'(bus.validB), 32'h1);
    #2;
    resetN = 1'b0;
    #1;
    check("midrst_validA", 32'(bus.validA), 32'h0);
    check("midrst_validB", 32'(bus.validB), 32'h0);
    check("midrst_countA", 32'(bus.countA), 32'h0);
    check("midrst_countB", 32'(bus.countB), 32'h0);
    check("midrst_dataOutA", bus.dataOutA, 32'h0);
    check("midrst_ready", 32'(bus.dataInReady), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);

    // Counter wrap: 65536 deliveries on B, nothing on A.
    acc = 0;
    del = 0;
    for (int cyc = 0; cyc < 70000 && !(acc == 65536 && del == 65536); cyc++) begin
      @(negedge clk);
      bus.dataSel     = 1'b1;
      bus.dataIn      = 32'(acc);
      bus.dataInValid = (acc < 65536);
      bus.readyA      = 1'b0;
      bus.readyB      = (del < 65536);
      #1;
      if (bus.dataInValid && bus.dataInReady) acc++;
      if (bus.validB && bus.readyB) begin
        del++;
        if (del == 65536) check("wrap_countB_before", 32'(bus.countB), 32'h0000FFFF);
      end
    end
    check("wrap_deliveries", 32'(del), 32'd65536);
    @(posedge clk);
    #1;
    check("wrap_countB_after", 32'(bus.countB), 32'h0);
    check("wrap_countA", 32'(bus.countA), 32'h0);
    check("wrap_validB", 32'(bus.validB), 32'h0);
    check("wrap_last_dataOutB", bus.dataOutB, 32'd65535);

    // Random traffic against a queue scoreboard, starting from a fresh reset.
    @(negedge clk);
    idle_inputs();
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    exp_ca = 0;
    exp_cb = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      bus.dataInValid = 1'($urandom_range(0, 1));
      bus.dataSel     = 1'($urandom_range(0, 1));
      bus.dataIn      = $urandom;
      bus.readyA      = 1'($urandom_range(0, 1));
      bus.readyB      = 1'($urandom_range(0, 1));
      #1;
      model_cycle();
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      bus.dataInValid = 1'b0;
      bus.readyA      = 1'b1;
      bus.readyB      = 1'b1;
      #1;
      model_cycle();
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("rand_drainA", 32'(qa.size()), 32'h0);
    check("rand_drainB", 32'(qb.size()), 32'h0);
    check("rand_countA", 32'(bus.countA), 32'(16'(exp_ca)));
    check("rand_countB", 32'(bus.countB), 32'(16'(exp_cb)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
